// File: rtl/hatch_obi_arbiter.sv
// -----------------------------------------------------------------------------
// hatch_obi_arbiter
//   Two-master (instruction + data) to one-slave OBI arbiter. Grants are
//   zero-latency pass-throughs of mem_gnt_i. An ungranted address phase locks
//   the selection until it is accepted. A route FIFO records the port of every
//   accepted transaction, so responses are steered back in grant order.
//
// Parameters
//   MAX_OUTSTANDING : granted-but-unanswered transactions allowed (1..8)
//
// Configuration macro
//   HATCH_OBI_ARB_RR_EN : defined   -> unlocked contention alternates ports
//                         undefined -> fixed data-over-instruction priority
//
// Ports
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   instr_req/gnt/addr/attr       : instruction address phase
//   instr_rvalid/rdata/err        : instruction response phase
//   data_req/gnt/addr/we/be/wdata/attr : data address phase
//   data_rvalid/rdata/err/exokay  : data response phase
//   mem_req/gnt/addr/we/be/wdata/attr  : shared memory address phase
//   mem_rvalid/rdata/err/exokay   : shared memory response phase
//   All outputs are forced to 0 while rst_ni is low.
// -----------------------------------------------------------------------------
module hatch_obi_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   input  logic [5:0]  instr_attr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   input  logic [11:0] data_attr_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        data_exokay_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   output logic [11:0] mem_attr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   input  logic        mem_exokay_i
);

   localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   port_e          r_route [2**AW];
   logic [AW-1:0]  r_rd_ptr;
   logic [AW-1:0]  r_wr_ptr;
   logic [CW-1:0]  r_count;
   logic           r_locked;
   port_e          r_lock_sel;
`ifdef HATCH_OBI_ARB_RR_EN
   logic           r_rr_data_first;
`endif

   port_e          w_sel;
   port_e          w_head;
   logic           w_req;
   logic           w_push;
   logic           w_pop;

   always_comb begin
      w_sel = PORT_INSTR;
      if (r_locked) begin
         w_sel = r_lock_sel;
      end else if (instr_req_i && data_req_i) begin
`ifdef HATCH_OBI_ARB_RR_EN
         w_sel = r_rr_data_first ? PORT_DATA : PORT_INSTR;
`else
         w_sel = PORT_DATA;
`endif
      end else if (data_req_i) begin
         w_sel = PORT_DATA;
      end
      // Fullness uses the registered count only: a same-cycle pop never frees a slot.
      w_req  = (instr_req_i || data_req_i) && (r_count < CW'(MAX_OUTSTANDING));
      w_push = w_req && mem_gnt_i;
      w_pop  = mem_rvalid_i && (r_count != '0);
      w_head = r_route[r_rd_ptr];
   end

   always_comb begin
      mem_req_o      = 1'b0;
      mem_addr_o     = '0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_wdata_o    = '0;
      mem_attr_o     = '0;
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      instr_rdata_o  = '0;
      data_rdata_o   = '0;
      instr_err_o    = 1'b0;
      data_err_o     = 1'b0;
      data_exokay_o  = 1'b0;
      if (rst_ni) begin
         mem_req_o = w_req;
         if (w_sel == PORT_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
            mem_attr_o  = data_attr_i;
            data_gnt_o  = w_push;
         end else begin
            mem_addr_o  = instr_addr_i;
            mem_be_o    = 4'hF;
            mem_attr_o  = {6'b0, instr_attr_i};
            instr_gnt_o = w_push;
         end
         instr_rvalid_o = w_pop && (w_head == PORT_INSTR);
         data_rvalid_o  = w_pop && (w_head == PORT_DATA);
         instr_rdata_o  = mem_rdata_i;
         data_rdata_o   = mem_rdata_i;
         instr_err_o    = mem_err_i;
         data_err_o     = mem_err_i;
         data_exokay_o  = mem_exokay_i && (r_count != '0) && (w_head == PORT_DATA);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_locked   <= 1'b0;
         r_lock_sel <= PORT_INSTR;
         for (int unsigned i = 0; i < 2**AW; i++) begin
            r_route[i] <= PORT_INSTR;
         end
      end else begin
         if (w_push) begin
            r_route[r_wr_ptr] <= w_sel;
            r_wr_ptr <= (r_wr_ptr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         // Hold the choice of an unaccepted address phase until it is granted.
         if (w_req && !mem_gnt_i) begin
            r_locked   <= 1'b1;
            r_lock_sel <= w_sel;
         end else if (w_push) begin
            r_locked <= 1'b0;
         end
      end
   end

`ifdef HATCH_OBI_ARB_RR_EN
   // The loser of a contended grant is preferred next time.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rr_data_first <= 1'b1;
      end else if (w_push && instr_req_i && data_req_i) begin
         r_rr_data_first <= (w_sel == PORT_INSTR);
      end
   end
`endif

endmodule

// File: tb/tb_hatch_obi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hatch_obi_arbiter
//   Self-checking bench for hatch_obi_arbiter: directed scenarios followed by
//   randomized traffic, all compared against a queue-based reference model.
//   Honours HATCH_OBI_ARB_RR_EN for the expected arbitration order.
// -----------------------------------------------------------------------------
module tb_hatch_obi_arbiter;

   localparam int unsigned MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_req, instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_addr, instr_rdata;
   logic [5:0]  instr_attr;
   logic        data_req, data_gnt, data_we, data_rvalid, data_err, data_exokay;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_be;
   logic [11:0] data_attr;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, mem_exokay;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic [11:0] mem_attr;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model state: port of each outstanding transaction (1 = data),
   // pending ungranted address phase, and contention preference.
   bit m_q[$];
   bit m_pend;
   bit m_pend_data;
   bit m_data_first;
   bit e_req;
   bit e_sel;

   always #5 clk = ~clk;

   hatch_obi_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
      .instr_attr_i(instr_attr), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
      .instr_err_o(instr_err),
      .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
      .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
      .data_attr_i(data_attr), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
      .data_err_o(data_err), .data_exokay_o(data_exokay),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_attr_o(mem_attr),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .mem_exokay_i(mem_exokay)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      instr_req = 0; instr_addr = '0; instr_attr = '0;
      data_req = 0; data_addr = '0; data_we = 0; data_be = '0; data_wdata = '0; data_attr = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0; mem_exokay = 0;
   endtask

   // Let inputs settle, then compare every output with the model.
   task automatic eval_cycle();
      bit head_ok;
      bit head_data;
      #2;
      if (!rst_n) begin
         e_req = 0;
         e_sel = 0;
         check("rst_ctrl", {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid,
                            instr_err, data_err, data_exokay, mem_we}, '0);
         check("rst_addr", mem_addr, '0);
         check("rst_be_attr", {mem_be, mem_attr}, '0);
         check("rst_wdata", mem_wdata, '0);
         check("rst_rdata", {instr_rdata, data_rdata}, '0);
         return;
      end
      if (m_pend) e_sel = m_pend_data;
      else if (instr_req && data_req) begin
`ifdef HATCH_OBI_ARB_RR_EN
         e_sel = m_data_first;
`else
         e_sel = 1;
`endif
      end else e_sel = data_req;
      e_req = (instr_req || data_req) && (m_q.size() < MAXO);
      check("mem_req", mem_req, e_req);
      if (e_req) begin
         check("mem_addr", mem_addr, e_sel ? data_addr : instr_addr);
         check("mem_we", mem_we, e_sel ? data_we : 1'b0);
         check("mem_be", mem_be, e_sel ? data_be : 4'hF);
         check("mem_wdata", mem_wdata, e_sel ? data_wdata : 32'h0);
         check("mem_attr", mem_attr, e_sel ? data_attr : {6'b0, instr_attr});
      end
      check("instr_gnt", instr_gnt, e_req && mem_gnt && !e_sel);
      check("data_gnt", data_gnt, e_req && mem_gnt && e_sel);
      head_ok   = (m_q.size() > 0);
      head_data = head_ok ? m_q[0] : 1'b0;
      check("instr_rvalid", instr_rvalid, mem_rvalid && head_ok && !head_data);
      check("data_rvalid", data_rvalid, mem_rvalid && head_ok && head_data);
      check("data_exokay", data_exokay, head_data && mem_exokay);
      check("rdata_fwd", {instr_rdata, data_rdata}, {mem_rdata, mem_rdata});
      check("err_fwd", {instr_err, data_err}, {mem_err, mem_err});
   endtask

   // Advance the model by the current inputs, then move past the clock edge.
   task automatic next_cycle();
      if (!rst_n) begin
         m_q.delete();
         m_pend = 0;
         m_pend_data = 0;
         m_data_first = 1;
      end else begin
         if (mem_rvalid && m_q.size() > 0) void'(m_q.pop_front());
         if (e_req && mem_gnt) begin
            m_q.push_back(e_sel);
            m_pend = 0;
            if (instr_req && data_req) m_data_first = !e_sel;
         end else if (e_req) begin
            m_pend = 1;
            m_pend_data = e_sel;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      eval_cycle();
      next_cycle();
      rst_n = 1;
   endtask

   task automatic drive_random();
      rst_n = ($urandom_range(0, 99) != 0);
      if (!(m_pend && !m_pend_data)) begin
         instr_req  = 1'($urandom);
         instr_addr = $urandom;
         instr_attr = 6'($urandom);
      end
      if (!(m_pend && m_pend_data)) begin
         data_req   = 1'($urandom);
         data_addr  = $urandom;
         data_we    = 1'($urandom);
         data_be    = 4'($urandom);
         data_wdata = $urandom;
         data_attr  = 12'($urandom);
      end
      mem_gnt    = ($urandom_range(0, 9) < 6);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      mem_err    = 1'($urandom);
      mem_exokay = 1'($urandom);
   endtask

   logic [3:0] exp_pattern;

   initial begin
      idle();
      rst_n = 0;
      m_q.delete(); m_pend = 0; m_pend_data = 0; m_data_first = 1;
      @(posedge clk); #1;

      // Reset state with every input active.
      instr_req = 1; data_req = 1; data_addr = 32'hDEAD_BEEF; mem_gnt = 1;
      mem_rvalid = 1; mem_rdata = 32'h1234_5678; mem_err = 1; mem_exokay = 1;
      eval_cycle();
      next_cycle();
      do_reset();

      // Stalled data write keeps address and blocks the instruction port.
      data_req = 1; data_we = 1; data_addr = 32'h100; data_be = 4'h3; data_wdata = 32'hCAFE;
      eval_cycle();
      check("stall_addr0", mem_addr, 32'h100);
      next_cycle();
      instr_req = 1; instr_addr = 32'h2000;
      for (int i = 0; i < 3; i++) begin
         eval_cycle();
         check("stall_addr", mem_addr, 32'h100);
         check("stall_igrant", instr_gnt, 1'b0);
         next_cycle();
      end
      mem_gnt = 1;
      eval_cycle();
      check("stall_dgrant", data_gnt, 1'b1);
      next_cycle();

      // Continuous contention with immediate grants.
      do_reset();
`ifdef HATCH_OBI_ARB_RR_EN
      exp_pattern = 4'b0101;
`else
      exp_pattern = 4'b1111;
`endif
      instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
      for (int i = 0; i < 4; i++) begin
         eval_cycle();
         check("contend_dgnt", data_gnt, exp_pattern[i]);
         check("contend_ignt", instr_gnt, !exp_pattern[i]);
         next_cycle();
      end

      // Outstanding limit: a pop in the same cycle does not free a slot.
      do_reset();
      instr_req = 1; mem_gnt = 1;
      eval_cycle(); next_cycle();
      eval_cycle(); next_cycle();
      eval_cycle();
      check("full_req", mem_req, 1'b0);
      next_cycle();
      mem_rvalid = 1;
      eval_cycle();
      check("full_pop_req", mem_req, 1'b0);
      check("full_pop_rv", instr_rvalid, 1'b1);
      next_cycle();
      mem_rvalid = 0;
      eval_cycle();
      check("after_pop_req", mem_req, 1'b1);
      next_cycle();

      // In-order response steering with exclusive-okay.
      do_reset();
      instr_req = 1; mem_gnt = 1;
      eval_cycle(); next_cycle();
      instr_req = 0; data_req = 1;
      eval_cycle(); next_cycle();
      data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_exokay = 1; mem_rdata = 32'hAAAA_0000;
      eval_cycle();
      check("resp1_irv", instr_rvalid, 1'b1);
      check("resp1_rdata", instr_rdata, 32'hAAAA_0000);
      check("resp1_exok", data_exokay, 1'b0);
      next_cycle();
      mem_rdata = 32'h5555_FFFF;
      eval_cycle();
      check("resp2_drv", data_rvalid, 1'b1);
      check("resp2_rdata", data_rdata, 32'h5555_FFFF);
      check("resp2_exok", data_exokay, 1'b1);
      next_cycle();

      // Reset abandons outstanding transactions.
      do_reset();
      instr_req = 1; mem_gnt = 1;
      eval_cycle(); next_cycle();
      eval_cycle(); next_cycle();
      do_reset();
      mem_rvalid = 1;
      eval_cycle();
      check("orphan_irv", instr_rvalid, 1'b0);
      check("orphan_drv", data_rvalid, 1'b0);
      next_cycle();
      mem_rvalid = 0; instr_req = 1; mem_gnt = 1;
      eval_cycle(); next_cycle();
      eval_cycle();
      check("orphan_cnt0", mem_req, 1'b1);
      next_cycle();

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         eval_cycle();
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
